// File: rtl/timer_multi_wb.sv
// Multi-channel Wishbone timer: NUM_CH up-counters share one prescaler. Each channel has PWM and a terminal-count IRQ.
// Latency: ACK/ERR and read data are registered and appear one cycle after the request.
// Backpressure: none. A held strobe completes every second cycle; ERR is returned for unmapped addresses.
module timer_multi_wb #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              irq
);

    // Bus response registers
    logic              r_ack;
    logic              r_err;
    logic [31:0]       r_dat;

    // Global registers and prescaler
    logic              r_gen;
    logic [PRE_W-1:0]  r_pre;
    logic [PRE_W-1:0]  r_pcnt;
    logic [NUM_CH-1:0] r_irq_stat;
    logic [NUM_CH-1:0] r_irq_en;

    // Per-channel state
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_per;
    logic [NUM_CH-1:0] r_pwm_en;
    logic [NUM_CH-1:0] r_pwm;
    logic [CNT_W-1:0]  r_load  [NUM_CH];
    logic [CNT_W-1:0]  r_cmp   [NUM_CH];
    logic [CNT_W-1:0]  r_count [NUM_CH];

    logic [7:0]        w_a;
    logic [3:0]        w_blk;
    logic [1:0]        w_off;
    logic              w_req;
    logic              w_err;
    logic              w_wr_g;
    logic              w_tick;
    logic [31:0]       w_mask;
    logic [31:0]       w_rdat;
    logic [31:0]       w_gctrl_new;
    logic [NUM_CH-1:0] w_ch_wr;
    logic [NUM_CH-1:0] w_set;
    logic [NUM_CH-1:0] w_w1c;
    logic              w_unused;

    // Replace only the byte lanes enabled by wb_sel_i.
    function automatic logic [31:0] f_merge(input logic [31:0] i_old, input logic [31:0] i_new,
                                            input logic [31:0] i_mask);
        return (i_old & ~i_mask) | (i_new & i_mask);
    endfunction

    // Only the low address byte is decoded.
    assign w_unused = ^wb_adr_i[31:8];

    assign w_a    = wb_adr_i[7:0];
    assign w_blk  = w_a[7:4];
    assign w_off  = w_a[3:2];
    assign w_req  = wb_stb_i & wb_cyc_i & ~r_ack & ~r_err;
    // Block 0 is global, block n+1 is channel n; anything beyond the last channel is unmapped.
    assign w_err  = (w_a[1:0] != 2'b00) || ({28'd0, w_blk} > 32'(NUM_CH));
    assign w_wr_g = w_req & wb_we_i & ~w_err & (w_blk == 4'd0);
    assign w_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_tick = r_gen & (r_pcnt == r_pre);

    assign w_gctrl_new = f_merge({r_gen, 31'd0} | 32'(r_pre), wb_dat_i, w_mask);
    assign w_w1c = (w_wr_g && w_off == 2'd1) ? NUM_CH'(wb_dat_i & w_mask) : '0;

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;
    assign pwm_o    = r_pwm;
    assign irq      = |(r_irq_stat & r_irq_en);

    // Per-channel write strobes and terminal-count events
    always_comb begin
        w_ch_wr = '0;
        w_set   = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_ch_wr[n] = w_req & wb_we_i & ~w_err & (w_blk == 4'(n + 1));
            w_set[n]   = w_tick & r_en[n] & (r_count[n] == r_load[n]);
        end
    end

    // Read data multiplexer
    always_comb begin
        w_rdat = '0;
        if (w_blk == 4'd0) begin
            case (w_off)
                2'd0: begin
                    w_rdat[PRE_W-1:0] = r_pre;
                    w_rdat[31]        = r_gen;
                end
                2'd1:    w_rdat[NUM_CH-1:0] = r_irq_stat;
                2'd2:    w_rdat[NUM_CH-1:0] = r_irq_en;
                default: begin
                    w_rdat[7:0]  = 8'(NUM_CH);
                    w_rdat[15:8] = 8'(CNT_W);
                end
            endcase
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_blk == 4'(n + 1)) begin
                    case (w_off)
                        2'd0:    w_rdat[2:0] = {r_pwm_en[n], r_per[n], r_en[n]};
                        2'd1:    w_rdat = 32'(r_load[n]);
                        2'd2:    w_rdat = 32'(r_cmp[n]);
                        default: w_rdat = 32'(r_count[n]);
                    endcase
                end
            end
        end
    end

    // Bus response: one ACK or ERR pulse per request; data is zero outside read ACKs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req & ~w_err;
            r_err <= w_req & w_err;
            r_dat <= (w_req & ~w_err & ~wb_we_i) ? w_rdat : '0;
        end
    end

    // Global registers; a hardware IRQ set beats a W1C in the same cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_gen      <= 1'b0;
            r_pre      <= '0;
            r_irq_en   <= '0;
            r_irq_stat <= '0;
        end else begin
            if (w_wr_g && w_off == 2'd0) begin
                r_pre <= PRE_W'(w_gctrl_new);
                r_gen <= w_gctrl_new[31];
            end
            if (w_wr_g && w_off == 2'd2)
                r_irq_en <= NUM_CH'(f_merge(32'(r_irq_en), wb_dat_i, w_mask));
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_set;
        end
    end

    // Prescaler: wraps at PRESCALE, and also (without a tick) if PRESCALE was lowered below it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_pcnt <= '0;
        else if (!r_gen || r_pcnt >= r_pre)
            r_pcnt <= '0;
        else
            r_pcnt <= r_pcnt + PRE_W'(1);
    end

    // Channel counters, control and PWM; bus writes are applied after the tick so LOAD_CMD wins
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_en     <= '0;
            r_per    <= '0;
            r_pwm_en <= '0;
            r_pwm    <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_load[n]  <= '0;
                r_cmp[n]   <= '0;
                r_count[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_tick && r_en[n]) begin
                    if (r_count[n] != r_load[n])
                        r_count[n] <= r_count[n] + CNT_W'(1);
                    else if (r_per[n])
                        r_count[n] <= '0;
                    else
                        r_en[n] <= 1'b0;
                end
                if (w_ch_wr[n]) begin
                    case (w_off)
                        2'd0: begin
                            if (wb_sel_i[0]) begin
                                r_en[n]     <= wb_dat_i[0];
                                r_per[n]    <= wb_dat_i[1];
                                r_pwm_en[n] <= wb_dat_i[2];
                                if (wb_dat_i[3])
                                    r_count[n] <= '0;
                            end
                        end
                        2'd1:    r_load[n] <= CNT_W'(f_merge(32'(r_load[n]), wb_dat_i, w_mask));
                        2'd2:    r_cmp[n]  <= CNT_W'(f_merge(32'(r_cmp[n]), wb_dat_i, w_mask));
                        default: ;
                    endcase
                end
                r_pwm[n] <= r_pwm_en[n] & r_en[n] & (r_count[n] < r_cmp[n]);
            end
        end
    end

endmodule

// File: tb/tb_timer_multi_wb.sv
// Bench for timer_multi_wb: directed scenarios plus random bus traffic against a behavioural model.
// Responses are queued at request time and checked by an independent monitor on the falling edge.
// PWM and IRQ outputs are compared against the model every cycle.
module tb_timer_multi_wb;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       adr = '0;
    logic [31:0]       wdat = '0;
    logic              we = 1'b0;
    logic              stb = 1'b0;
    logic              cyc = 1'b0;
    logic [3:0]        sel = '0;
    logic [31:0]       dat_o;
    logic              ack;
    logic              err;
    logic [NCH-1:0]    pwm;
    logic              irq;

    int checks   = 0;
    int failures = 0;

    timer_multi_wb #(.NUM_CH(NCH), .CNT_W(32), .PRE_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_sel_i(sel),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .pwm_o(pwm), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] dat;
    } resp_t;
    resp_t sb[$];

    // Behavioural model state
    logic           m_gen;
    logic [15:0]    m_pre;
    logic [15:0]    m_pcnt;
    logic [NCH-1:0] m_stat, m_ien, m_en, m_per, m_pwe, m_pwm;
    logic [31:0]    m_load [NCH];
    logic [31:0]    m_cmp  [NCH];
    logic [31:0]    m_cnt  [NCH];
    logic           m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++)
            if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic addr_err(input logic [7:0] a);
        int blk = int'(a[7:4]);
        if (a[1:0] != 2'b00) return 1'b1;
        return (blk != 0) && (blk - 1 >= NCH);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int blk = int'(a[7:4]);
        int off = int'(a[3:2]);
        int ch  = blk - 1;
        if (blk == 0) begin
            case (off)
                0:       return {m_gen, 15'd0, m_pre};
                1:       return 32'(m_stat);
                2:       return 32'(m_ien);
                default: return 32'(NCH) | (32'd32 << 8);
            endcase
        end
        case (off)
            0:       return {29'd0, m_pwe[ch], m_per[ch], m_en[ch]};
            1:       return m_load[ch];
            2:       return m_cmp[ch];
            default: return m_cnt[ch];
        endcase
    endfunction

    task automatic model_reset();
        m_gen = 0; m_pre = 0; m_pcnt = 0; m_stat = 0; m_ien = 0;
        m_en = 0; m_per = 0; m_pwe = 0; m_pwm = 0; m_pend = 0;
        for (int n = 0; n < NCH; n++) begin
            m_load[n] = 0; m_cmp[n] = 0; m_cnt[n] = 0;
        end
    endtask

    // One clock of the specified behaviour, evaluated from the state before the edge.
    task automatic model_step();
        logic [NCH-1:0] npwm, set, w1c;
        logic [7:0]     a;
        logic [31:0]    g;
        logic           req, e, tick;
        int             blk, off, ch;
        resp_t          r;
        a   = adr[7:0];
        blk = int'(a[7:4]);
        off = int'(a[3:2]);
        ch  = blk - 1;
        req = stb && cyc && !m_pend;
        e   = addr_err(a);
        for (int n = 0; n < NCH; n++)
            npwm[n] = m_pwe[n] && m_en[n] && (m_cnt[n] < m_cmp[n]);
        if (req) begin
            r.err = e;
            r.rd  = !we;
            r.dat = (e || we) ? 32'd0 : model_read(a);
            sb.push_back(r);
        end
        m_pend = req;
        tick = m_gen && (m_pcnt == m_pre);
        m_pcnt = (!m_gen || m_pcnt >= m_pre) ? 16'd0 : m_pcnt + 16'd1;
        set = 0;
        w1c = 0;
        for (int n = 0; n < NCH; n++) begin
            if (tick && m_en[n]) begin
                if (m_cnt[n] == m_load[n]) begin
                    set[n] = 1'b1;
                    if (m_per[n]) m_cnt[n] = 0;
                    else          m_en[n]  = 1'b0;
                end else begin
                    m_cnt[n] = m_cnt[n] + 1;
                end
            end
        end
        if (req && we && !e) begin
            if (blk == 0) begin
                case (off)
                    0: begin
                        g = lanes({m_gen, 15'd0, m_pre}, wdat, sel);
                        m_pre = g[15:0];
                        m_gen = g[31];
                    end
                    1: begin g = lanes(32'd0, wdat, sel); w1c = g[NCH-1:0]; end
                    2: begin g = lanes(32'(m_ien), wdat, sel); m_ien = g[NCH-1:0]; end
                    default: ;
                endcase
            end else begin
                case (off)
                    0: if (sel[0]) begin
                        m_en[ch]  = wdat[0];
                        m_per[ch] = wdat[1];
                        m_pwe[ch] = wdat[2];
                        if (wdat[3]) m_cnt[ch] = 0;
                    end
                    1: m_load[ch] = lanes(m_load[ch], wdat, sel);
                    2: m_cmp[ch]  = lanes(m_cmp[ch], wdat, sel);
                    default: ;
                endcase
            end
        end
        m_stat = (m_stat & ~w1c) | set;
        m_pwm  = npwm;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Monitor: response timing and data, PWM and IRQ every cycle
    always @(negedge clk) begin
        resp_t r;
        if (!rst) begin
            if (m_pend) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
                end else begin
                    r = sb.pop_front();
                    check("ack", 32'(ack), 32'(!r.err));
                    check("err", 32'(err), 32'(r.err));
                    if (r.rd && !r.err) check("rdata", dat_o, r.dat);
                end
            end else begin
                check("idle_ackerr", {30'd0, ack, err}, 32'd0);
                check("idle_dat", dat_o, 32'd0);
            end
            check("pwm", 32'(pwm), 32'(m_pwm));
            check("irq", 32'(irq), 32'(|(m_stat & m_ien)));
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic c, output logic [31:0] rdv);
        @(negedge clk);
        adr = a; wdat = d; we = w; sel = s; stb = 1'b1; cyc = c;
        @(negedge clk);
        rdv = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        bus(1'b1, a, d, 4'hF, 1'b1, unused_rd);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus(1'b0, a, 32'd0, 4'hF, 1'b1, v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_pwm(input int ch, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm[ch]) hi++;
        end
    endtask

    initial begin
        #1_000_000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] v, a, d;
        logic [3:0]  s;
        int          hi, acks, blk, off;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        idle(2);

        // Identification and unmapped accesses
        rd(32'h0C, v);
        check("info", v, 32'h0000_2004);
        rd(32'h50, v);
        rd(32'h02, v);
        rd(32'hFFFF_FF0C, v);
        check("info_upper_adr", v, 32'h0000_2004);

        // Periodic channel 0 at a tick every 3 cycles
        wr(32'h00, 32'h8000_0002);
        wr(32'h14, 32'd3);
        wr(32'h08, 32'd1);
        wr(32'h10, 32'h3);
        idle(20);
        rd(32'h04, v);
        check("periodic_irq_stat", v & 32'h1, 32'h1);
        check("periodic_irq_pin", 32'(irq), 32'd1);
        wr(32'h10, 32'h0);
        wr(32'h04, 32'h1);
        idle(2);
        rd(32'h04, v);
        check("w1c_cleared", v & 32'h1, 32'h0);

        // One-shot channel 1
        wr(32'h24, 32'd2);
        wr(32'h20, 32'h1);
        wr(32'h00, 32'h8000_0000);
        idle(10);
        rd(32'h20, v);
        check("oneshot_en_clear", v, 32'h0);
        rd(32'h2C, v);
        check("oneshot_hold", v, 32'd2);
        rd(32'h04, v);
        check("oneshot_irq", v & 32'h2, 32'h2);
        wr(32'h04, 32'h2);
        idle(6);
        rd(32'h04, v);
        check("oneshot_once", v & 32'h2, 32'h0);

        // PWM on channel 2
        wr(32'h34, 32'd9);
        wr(32'h38, 32'd4);
        wr(32'h30, 32'h7);
        idle(12);
        count_pwm(2, 20, hi);
        check("pwm_duty_4of10", 32'(hi), 32'd8);
        wr(32'h38, 32'd0);
        idle(2);
        count_pwm(2, 20, hi);
        check("pwm_cmp0", 32'(hi), 32'd0);
        wr(32'h38, 32'd20);
        idle(2);
        count_pwm(2, 20, hi);
        check("pwm_cmp_gt_load", 32'(hi), 32'd20);
        wr(32'h30, 32'h0);

        // Byte-lane write
        wr(32'h44, 32'hFFFF_FFFF);
        bus(1'b1, 32'h44, 32'h0, 4'h2, 1'b1, v);
        rd(32'h44, v);
        check("byte_lane", v, 32'hFFFF_00FF);

        // W1C colliding with an event on every tick, then LOAD_CMD against a tick
        wr(32'h14, 32'd0);
        wr(32'h10, 32'h3);
        idle(3);
        wr(32'h04, 32'h1);
        rd(32'h04, v);
        check("collision_set_wins", v & 32'h1, 32'h1);
        wr(32'h14, 32'd100);
        idle(8);
        wr(32'h10, 32'hB);
        rd(32'h1C, v);
        check("loadcmd_restart", 32'(v < 32'd4), 32'd1);
        wr(32'h10, 32'h0);

        // Prescaler lowered below the running count
        wr(32'h00, 32'h8000_000A);
        idle(7);
        wr(32'h00, 32'h8000_0001);
        idle(4);

        // Held strobe: requests complete every second cycle
        @(negedge clk);
        adr = 32'h0C; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        check("held_strobe_acks", 32'(acks), 32'd3);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, 255));
                1:       a = 32'h50 + 4 * $urandom_range(0, 43);
                2, 3:    a = 4 * $urandom_range(0, 3);
                default: a = 32'h10 + 16 * $urandom_range(0, 3) + 4 * $urandom_range(0, 3);
            endcase
            a   = a | ($urandom & 32'hFFFF_FF00);
            blk = int'(a[7:4]);
            off = int'(a[3:2]);
            d   = $urandom;
            if (blk == 0 && off == 0)
                d = (($urandom_range(0, 4) != 0) ? 32'h8000_0000 : 32'd0) | (d & 32'h7FFF_0000)
                    | 32'($urandom_range(0, 3));
            else if (blk != 0 && (off == 1 || off == 2) && $urandom_range(0, 7) != 0)
                d = 32'($urandom_range(0, 12));
            else if (blk != 0 && off == 0)
                d = (d & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
            s = ($urandom_range(0, 4) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            bus(1'($urandom_range(0, 9) < 6), a, d, s, 1'($urandom_range(0, 9) != 0), v);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end

        idle(5);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
